// File: rtl/tm1637_pkg.sv
// Shared definitions for the TM1637 display driver: command bytes, bus FSM
// states and the byte layout of the three frames sent per update.
package tm1637_pkg;

  localparam logic [7:0] CMD_DATA_WRITE = 8'h40;
  localparam logic [7:0] CMD_ADDR0      = 8'hC0;
  localparam logic [7:0] CMD_DISPLAY    = 8'h80;

  localparam logic [2:0] FRAME1_BYTES = 3'd1;
  localparam logic [2:0] FRAME2_BYTES = 3'd5;
  localparam logic [2:0] FRAME3_BYTES = 3'd1;
  localparam logic [1:0] LAST_FRAME   = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_ACK_LO,
    ST_ACK_HI,
    ST_STOP_A,
    ST_STOP_B,
    ST_STOP_C
  } state_t;

  function automatic logic [2:0] frame_len(input logic [1:0] frame);
    case (frame)
      2'd0:    return FRAME1_BYTES;
      2'd1:    return FRAME2_BYTES;
      default: return FRAME3_BYTES;
    endcase
  endfunction

endpackage

// File: rtl/tm1637_display_if.sv
// Host-side request/status signals and TM1637 pin signals of tm1637_display.
interface tm1637_display_if;

  logic [3:0] thousands;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       colon;
  logic [2:0] brightness;
  logic       display_on;
  logic       update;
  logic       busy;
  logic       ack_err;
  logic       tm_clk;
  logic       tm_dio_oe;
  logic       tm_dio_in;

  modport master (
    output thousands, hundreds, tens, ones, colon, brightness, display_on,
           update, tm_dio_in,
    input  busy, ack_err, tm_clk, tm_dio_oe
  );

  modport slave (
    input  thousands, hundreds, tens, ones, colon, brightness, display_on,
           update, tm_dio_in,
    output busy, ack_err, tm_clk, tm_dio_oe
  );

endinterface

// File: rtl/tm1637_display_seg7_encode.sv
// BCD digit to 7-segment pattern (gfedcba); non-decimal codes render blank.
module seg7_encode (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/tm1637_display.sv
// TM1637 4-digit driver: snapshots digits on update and sends the data-command,
// address+data and display-control frames over the two-wire bus.
module tm1637_display
  import tm1637_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50,
  parameter bit          LEAD_BLANK = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  tm1637_display_if.slave   bus
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t        state, state_n;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          accept;

  logic [1:0] frame, frame_n;
  logic [2:0] bidx, bidx_n;
  logic [2:0] ptr, ptr_n;
  logic [2:0] bitn, bitn_n;
  logic       ack_err_q, ack_err_n;
  logic       clk_q, clk_n;
  logic       oe_q, oe_n;

  logic [3:0] d_th, d_hu, d_te, d_on;
  logic       r_colon;
  logic [2:0] r_bright;
  logic       r_on;

  logic [6:0] seg_th, seg_hu, seg_te, seg_on;
  logic       blank_th, blank_hu, blank_te;
  logic [7:0] byte_n;

  assign accept = bus.update && (state == ST_IDLE);
  assign tick   = (tick_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (state == ST_IDLE || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_th     <= '0;
      d_hu     <= '0;
      d_te     <= '0;
      d_on     <= '0;
      r_colon  <= 1'b0;
      r_bright <= '0;
      r_on     <= 1'b0;
    end else if (accept) begin
      d_th     <= bus.thousands;
      d_hu     <= bus.hundreds;
      d_te     <= bus.tens;
      d_on     <= bus.ones;
      r_colon  <= bus.colon;
      r_bright <= bus.brightness;
      r_on     <= bus.display_on;
    end
  end

  seg7_encode u_seg_th (.bcd(d_th), .seg(seg_th));
  seg7_encode u_seg_hu (.bcd(d_hu), .seg(seg_hu));
  seg7_encode u_seg_te (.bcd(d_te), .seg(seg_te));
  seg7_encode u_seg_on (.bcd(d_on), .seg(seg_on));

  // Blanking only propagates rightwards through an unbroken run of zeros.
  assign blank_th = LEAD_BLANK && (d_th == 4'd0);
  assign blank_hu = blank_th && (d_hu == 4'd0);
  assign blank_te = blank_hu && (d_te == 4'd0);

  always_comb begin
    byte_n = '0;
    case (ptr_n)
      3'd0:    byte_n = CMD_DATA_WRITE;
      3'd1:    byte_n = CMD_ADDR0;
      3'd2:    byte_n = {1'b0, blank_th ? 7'h00 : seg_th};
      3'd3:    byte_n = {r_colon, blank_hu ? 7'h00 : seg_hu};
      3'd4:    byte_n = {1'b0, blank_te ? 7'h00 : seg_te};
      3'd5:    byte_n = {1'b0, seg_on};
      3'd6:    byte_n = CMD_DISPLAY | {4'b0000, r_on, r_bright};
      default: byte_n = '0;
    endcase
  end

  always_comb begin
    state_n   = state;
    frame_n   = frame;
    bidx_n    = bidx;
    ptr_n     = ptr;
    bitn_n    = bitn;
    ack_err_n = ack_err_q;
    if (state == ST_IDLE) begin
      if (bus.update) begin
        state_n   = ST_START;
        frame_n   = '0;
        bidx_n    = '0;
        ptr_n     = '0;
        bitn_n    = '0;
        ack_err_n = 1'b0;
      end
    end else if (tick) begin
      case (state)
        ST_START:  state_n = ST_BIT_LO;
        ST_BIT_LO: state_n = ST_BIT_HI;
        ST_BIT_HI: begin
          if (bitn == 3'd7) begin
            state_n = ST_ACK_LO;
          end else begin
            bitn_n  = bitn + 3'd1;
            state_n = ST_BIT_LO;
          end
        end
        ST_ACK_LO: state_n = ST_ACK_HI;
        ST_ACK_HI: begin
          if (bus.tm_dio_in) ack_err_n = 1'b1;
          bitn_n = '0;
          if (bidx == frame_len(frame) - 3'd1) begin
            state_n = ST_STOP_A;
          end else begin
            bidx_n  = bidx + 3'd1;
            ptr_n   = ptr + 3'd1;
            state_n = ST_BIT_LO;
          end
        end
        ST_STOP_A: state_n = ST_STOP_B;
        ST_STOP_B: state_n = ST_STOP_C;
        ST_STOP_C: begin
          if (frame == LAST_FRAME) begin
            state_n = ST_IDLE;
          end else begin
            frame_n = frame + 2'd1;
            bidx_n  = '0;
            ptr_n   = ptr + 3'd1;
            state_n = ST_START;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Pin levels are decoded from the next state and registered, so they switch
  // on the same edge as the FSM and stay glitch-free.
  always_comb begin
    clk_n = 1'b1;
    oe_n  = 1'b0;
    case (state_n)
      ST_START:  begin clk_n = 1'b1; oe_n = 1'b1;           end
      ST_BIT_LO: begin clk_n = 1'b0; oe_n = ~byte_n[bitn_n]; end
      ST_BIT_HI: begin clk_n = 1'b1; oe_n = ~byte_n[bitn_n]; end
      ST_ACK_LO: begin clk_n = 1'b0; oe_n = 1'b0;           end
      ST_ACK_HI: begin clk_n = 1'b1; oe_n = 1'b0;           end
      ST_STOP_A: begin clk_n = 1'b0; oe_n = 1'b1;           end
      ST_STOP_B: begin clk_n = 1'b1; oe_n = 1'b1;           end
      ST_STOP_C: begin clk_n = 1'b1; oe_n = 1'b0;           end
      default:   begin clk_n = 1'b1; oe_n = 1'b0;           end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      frame     <= '0;
      bidx      <= '0;
      ptr       <= '0;
      bitn      <= '0;
      ack_err_q <= 1'b0;
      clk_q     <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      state     <= state_n;
      frame     <= frame_n;
      bidx      <= bidx_n;
      ptr       <= ptr_n;
      bitn      <= bitn_n;
      ack_err_q <= ack_err_n;
      clk_q     <= clk_n;
      oe_q      <= oe_n;
    end
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.ack_err   = ack_err_q;
  assign bus.tm_clk    = clk_q;
  assign bus.tm_dio_oe = oe_q;

endmodule

// File: tb/tb_tm1637_display.sv
// Scoreboard bench for tm1637_display: directed updates push expected bus
// bytes; a bus monitor decodes TM1637 traffic, models the ACKs and compares.
module tb_tm1637_display;

  localparam int unsigned DIV      = 4;
  localparam int unsigned XFER_CYC = 138 * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tm1637_display_if b0 ();
  tm1637_display_if b1 ();

  tm1637_display #(.CLK_DIV(DIV), .LEAD_BLANK(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  tm1637_display #(.CLK_DIV(DIV), .LEAD_BLANK(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  typedef struct packed {
    logic [7:0] val;
    logic       nack;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  bit   sel = 1'b0;
  bit   ack_drive = 1'b0;

  // Open-drain line: low if the DUT pulls or the modelled slave acknowledges.
  assign b0.tm_dio_in = !b0.tm_dio_oe && !ack_drive;
  assign b1.tm_dio_in = !b1.tm_dio_oe && !ack_drive;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endfunction

  function automatic logic f_busy();
    return sel ? b1.busy : b0.busy;
  endfunction
  function automatic logic f_ack_err();
    return sel ? b1.ack_err : b0.ack_err;
  endfunction
  function automatic logic f_tmclk();
    return sel ? b1.tm_clk : b0.tm_clk;
  endfunction
  function automatic logic f_oe();
    return sel ? b1.tm_dio_oe : b0.tm_dio_oe;
  endfunction

  // ---------------- bus monitor ----------------
  logic       p_clk = 1'b1;
  logic       p_oe = 1'b0;
  int         bc = 0;
  int         since = 0;
  bit         pvalid = 1'b0;
  bit         nack_cur = 1'b0;
  bit         last_seen = 1'b0;
  logic [7:0] sh = '0;

  always @(negedge clk) begin : mon
    logic c, o, bz;
    exp_t e;
    c  = f_tmclk();
    o  = f_oe();
    bz = f_busy();
    if (!rst_n) begin
      bc = 0; since = 0; pvalid = 1'b0; nack_cur = 1'b0; ack_drive = 1'b0;
    end else begin
      since++;
      if (c !== p_clk || o !== p_oe) begin
        if (!bz) begin
          checks++;
          $display("FAIL idle_bus_activity: clk/oe now %b/%b, required unchanged %b/%b", c, o, p_clk, p_oe);
        end else if (pvalid) begin
          chk("phase_len", since, DIV);
        end
        since = 0;
        if (o !== p_oe) chk("dio_change_clk_low", ((c == 1'b0) || (p_clk && c)), 1);
        if (p_clk && c && !p_oe && o) begin
          bc = 0;
          last_seen = 1'b0;
        end
        if (p_clk && c && p_oe && !o) chk("stop_after_last_byte", last_seen, 1);
        if (!p_clk && c) begin
          bc++;
          if (bc <= 8) sh = {!o, sh[7:1]};
          if (bc == 8) begin
            if (exp_q.size() == 0) begin
              checks++;
              $display("FAIL unexpected_byte: got %02h, required no byte", sh);
            end else begin
              e = exp_q.pop_front();
              chk("bus_byte", sh, e.val);
              nack_cur  = e.nack;
              last_seen = e.last;
            end
          end
        end
        if (p_clk && !c && bc == 9) bc = 0;
      end
      pvalid    = bz;
      ack_drive = !nack_cur && ((bc == 8 && !c) || bc == 9);
    end
    p_clk = c;
    p_oe  = o;
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic [3:0] th, hu, te, on, input logic col,
                        input logic [2:0] br, input logic don);
    b0.thousands = th; b0.hundreds = hu; b0.tens = te; b0.ones = on;
    b0.colon = col; b0.brightness = br; b0.display_on = don;
    b1.thousands = th; b1.hundreds = hu; b1.tens = te; b1.ones = on;
    b1.colon = col; b1.brightness = br; b1.display_on = don;
  endtask

  task automatic drive_update(input logic v);
    if (sel) b1.update = v;
    else     b0.update = v;
  endtask

  task automatic push_exp(input logic [31:0] dat, input logic [7:0] ctl, input int nack);
    logic [7:0] v [7];
    exp_t e;
    v = '{8'h40, 8'hC0, dat[31:24], dat[23:16], dat[15:8], dat[7:0], ctl};
    for (int i = 0; i < 7; i++) begin
      e.val  = v[i];
      e.nack = (i == nack);
      e.last = (i == 0 || i == 5 || i == 6);
      exp_q.push_back(e);
    end
  endtask

  task automatic xfer(input logic [3:0] th, hu, te, on, input logic col, input logic [2:0] br,
                      input logic don, input logic [31:0] dat, input logic [7:0] ctl,
                      input int nack, input bit poke, input logic exp_ack);
    int n;
    @(negedge clk);
    set_in(th, hu, te, on, col, br, don);
    push_exp(dat, ctl, nack);
    drive_update(1'b1);
    @(posedge clk); #1;
    drive_update(1'b0);
    chk("busy_after_accept", f_busy(), 1);
    chk("ack_err_cleared_on_accept", f_ack_err(), 0);
    n = 0;
    while (n < int'(XFER_CYC) + 20) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 100) begin
        set_in(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 3'd1, 1'b1);
        drive_update(1'b1);
      end else begin
        drive_update(1'b0);
      end
      if (nack == 1 && n == 163) chk("ack_err_before_nack_slot", f_ack_err(), 0);
      if (nack == 1 && n == 164) chk("ack_err_after_nack_slot", f_ack_err(), 1);
      if (!f_busy()) break;
    end
    chk("busy_cycles", n, XFER_CYC);
    chk("ack_err_final", f_ack_err(), exp_ack);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "timeout");
  end

  initial begin : stim
    set_in('0, '0, '0, '0, 1'b0, '0, 1'b0);
    b0.update = 1'b0;
    b1.update = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tm_clk", b0.tm_clk, 1);
    chk("reset_dio_oe", b0.tm_dio_oe, 0);
    chk("reset_busy", b0.busy, 0);
    chk("reset_ack_err", b0.ack_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    xfer(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 3'd7, 1'b1, 32'h06DB4F66, 8'h8F, -1, 1'b0, 1'b0);
    xfer(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 3'd7, 1'b1, 32'h06DB4F66, 8'h8F,  1, 1'b0, 1'b1);
    xfer(4'd5, 4'd6, 4'd7, 4'd8, 1'b0, 3'd3, 1'b0, 32'h6D7D077F, 8'h83, -1, 1'b1, 1'b0);
    xfer(4'd9, 4'd0, 4'd9, 4'd0, 1'b1, 3'd0, 1'b1, 32'h6FBF6F3F, 8'h88, -1, 1'b0, 1'b0);
    xfer(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 3'd1, 1'b1, 32'h3F3F3F3F, 8'h89, -1, 1'b0, 1'b0);

    @(negedge clk);
    sel = 1'b1;
    xfer(4'd0,  4'd0, 4'd0, 4'd7, 1'b0, 3'd2, 1'b1, 32'h00000007, 8'h8A, -1, 1'b0, 1'b0);
    xfer(4'd0,  4'd0, 4'd5, 4'd0, 1'b0, 3'd2, 1'b1, 32'h00006D3F, 8'h8A, -1, 1'b0, 1'b0);
    xfer(4'd12, 4'd3, 4'd0, 4'd1, 1'b0, 3'd5, 1'b0, 32'h004F3F06, 8'h85, -1, 1'b0, 1'b0);
    xfer(4'd0,  4'd0, 4'd0, 4'd0, 1'b1, 3'd7, 1'b1, 32'h0080003F, 8'h8F, -1, 1'b0, 1'b0);

    // Abort mid-frame: phase 16 is BIT_LO of bit 7 of 0x40 (clk low, DIO pulled).
    @(negedge clk);
    sel = 1'b0;
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 3'd7, 1'b1);
    push_exp(32'h06DB4F66, 8'h8F, -1);
    b0.update = 1'b1;
    @(posedge clk); #1;
    b0.update = 1'b0;
    repeat (61) @(posedge clk);
    #3;
    chk("pre_abort_tm_clk", b0.tm_clk, 0);
    chk("pre_abort_dio_oe", b0.tm_dio_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_tm_clk", b0.tm_clk, 1);
    chk("async_reset_dio_oe", b0.tm_dio_oe, 0);
    chk("async_reset_busy", b0.busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("post_reset_busy", b0.busy, 0);
    chk("post_reset_tm_clk", b0.tm_clk, 1);
    chk("post_reset_dio_oe", b0.tm_dio_oe, 0);

    xfer(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 3'd7, 1'b1, 32'h06DB4F66, 8'h8F, -1, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
